// File: rtl/column_frame_sched.sv
// Frame sequencer for the column pipeline: init pulse, prime discard,
// paced column transfer with index, frame-end checking and stall timeout.
`timescale 1ns/1ps
module column_frame_sched #(
    parameter int NCOLS    = 256,
    parameter int CW       = 8,
    parameter int INIT_CYC = 2,
    parameter int TO_W     = 12,
    parameter int TIMEOUT  = 1024,
    parameter int FW       = 16
) (
    input  logic          clock,
    input  logic          init_n,
    input  logic          start,
    input  logic          abort,
    output logic          stage_init,
    input  logic          pipe_rdy,
    input  logic          pipe_last,
    output logic          pipe_req,
    input  logic          sink_rdy,
    output logic          col_valid,
    output logic [CW-1:0] col_idx,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [FW-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_PRIME, S_RUN, S_DONE
    } state_t;

    localparam logic [CW-1:0]   LAST_IDX  = CW'(NCOLS - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] INIT_LAST = TO_W'(INIT_CYC - 1);

    state_t          state, state_n;
    logic [CW-1:0]   idx_n;
    logic [TO_W-1:0] to_q, to_n;
    logic            err_n;
    logic [FW-1:0]   fc_n;
    logic            init_st;
    logic            accept;
    logic            at_end;

    // Stages stay in init for as long as the sequencer itself is in reset.
    assign stage_init = init_st | ~init_n;

    always_comb begin
        state_n   = state;
        idx_n     = col_idx;
        to_n      = to_q;
        err_n     = err;
        fc_n      = frame_cnt;
        init_st   = 1'b0;
        pipe_req  = 1'b0;
        col_valid = 1'b0;
        accept    = pipe_rdy & sink_rdy & ~abort;
        at_end    = (col_idx == LAST_IDX);
        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_n = S_INIT;
                    err_n   = 1'b0;
                    idx_n   = '0;
                    to_n    = '0;
                end
            end
            S_INIT: begin
                init_st = 1'b1;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (to_q == INIT_LAST) begin
                    state_n = S_PRIME;
                    to_n    = '0;
                end else begin
                    to_n = to_q + 1'b1;
                end
            end
            S_PRIME: begin
                pipe_req = pipe_rdy & ~abort;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (pipe_rdy) begin
                    state_n = S_RUN;
                    to_n    = '0;
                end else if (to_q == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    to_n = to_q + 1'b1;
                end
            end
            S_RUN: begin
                col_valid = accept;
                pipe_req  = accept & ~pipe_last & ~at_end;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (!pipe_rdy) begin
                    if (to_q == TO_LAST) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        to_n = to_q + 1'b1;
                    end
                end else begin
                    to_n = '0;
                    // Frame ends on last or on the final index; a mismatch is an error.
                    if (sink_rdy) begin
                        if (pipe_last || at_end) begin
                            err_n   = err | (pipe_last ^ at_end);
                            state_n = S_DONE;
                        end else begin
                            idx_n = col_idx + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                if (!abort) fc_n = frame_cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge init_n) begin
        if (!init_n) begin
            state     <= S_IDLE;
            col_idx   <= '0;
            to_q      <= '0;
            err       <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= idx_n;
            to_q      <= to_n;
            err       <= err_n;
            frame_cnt <= fc_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_column_frame_sched.sv
// Randomized frame-level bench for column_frame_sched with a
// behavioural pipe model and frame scoreboard.
`timescale 1ns/1ps
module tb_column_frame_sched;

    localparam int NCOLS   = 256;
    localparam int CW      = 8;
    localparam int FW      = 16;
    localparam int TIMEOUT = 1024;

    localparam int K_NORM  = 0;
    localparam int K_TMO   = 1;
    localparam int K_ABORT = 2;
    localparam int K_RST   = 3;

    logic          clock = 1'b0;
    logic          init_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pipe_rdy = 1'b0;
    logic          pipe_last = 1'b0;
    logic          sink_rdy = 1'b0;
    logic          stage_init, pipe_req, col_valid;
    logic          busy, done, err;
    logic [CW-1:0] col_idx;
    logic [FW-1:0] frame_cnt;

    column_frame_sched dut (
        .clock(clock), .init_n(init_n), .start(start), .abort(abort),
        .stage_init(stage_init), .pipe_rdy(pipe_rdy),
        .pipe_last(pipe_last), .pipe_req(pipe_req),
        .sink_rdy(sink_rdy), .col_valid(col_valid), .col_idx(col_idx),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Pipe model: column number presented, ready flag, gap to next column.
    int p_col = -1;
    bit p_rdy = 1'b0;
    int p_gap = 1;
    int gmax = 0;
    bit p_stall = 1'b0;
    int cur_last = NCOLS - 1;
    int fc_exp = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic pipe_step(input bit req, input bit si);
        if (si) begin
            p_col = -1;
            p_rdy = 1'b0;
            p_gap = 1;
        end else if (req) begin
            p_rdy = 1'b0;
            p_col++;
            p_gap = $urandom_range(0, gmax);
        end else if (!p_rdy) begin
            if (p_gap == 0) p_rdy = !(p_stall && p_col >= 0);
            else p_gap--;
        end
        pipe_rdy  = p_rdy;
        pipe_last = p_rdy && (p_col == cur_last);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            expect_eq({tag, "_busy"}, busy, 0);
            expect_eq({tag, "_done"}, done, 0);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_frame(input int kind, input int last_at,
                             input int sink_pct, input int gm,
                             input int start_at, input int ev_at,
                             input int budget);
        int cyc, phase, acc_n, done_n, done_cyc, last_cyc;
        int si_n, cv_pre, low_n, abort_cyc, end_cyc, exp_cols;
        bit ended, s_req, s_si, exp_cv, live, exp_err;
        phase = 0; acc_n = 0; done_n = 0; done_cyc = -1;
        last_cyc = -1; si_n = 0; cv_pre = 0; low_n = 0;
        abort_cyc = -1; end_cyc = -1; ended = 1'b0;
        cur_last = last_at;
        gmax = gm;
        p_stall = (kind == K_TMO);
        for (cyc = 0; cyc < budget && !ended; cyc++) begin
            start = (cyc == 0);
            if (phase == 1 && acc_n == start_at) start = 1'b1;
            if (kind == K_ABORT && phase == 1 && acc_n == ev_at &&
                abort_cyc < 0) begin
                abort = 1'b1;
                start = 1'b1;
                abort_cyc = cyc;
            end
            sink_rdy = ($urandom_range(0, 99) < sink_pct);
            if (kind == K_RST && phase == 1 && acc_n == ev_at) begin
                #2 init_n = 1'b0;
                #1;
                expect_eq("rst_stage_init", stage_init, 1);
                expect_eq("rst_busy", busy, 0);
                expect_eq("rst_col_idx", col_idx, 0);
                expect_eq("rst_frame_cnt", frame_cnt, 0);
                expect_eq("rst_done", done, 0);
                expect_eq("rst_err", err, 0);
                expect_eq("rst_col_valid", col_valid, 0);
                expect_eq("rst_pipe_req", pipe_req, 0);
                fc_exp = 0;
                start = 1'b0;
                @(negedge clock);
                init_n = 1'b1;
                pipe_step(1'b0, 1'b1);
                @(posedge clock);
                #1;
                idle_cycles(4, "post_rst");
                ended = 1'b1;
                break;
            end
            @(negedge clock);
            if (stage_init) si_n++;
            if (cyc == 1) expect_eq("err_clr", err, 0);
            live = (phase == 1) && (abort_cyc < 0 || cyc == abort_cyc);
            if (live) begin
                exp_cv = pipe_rdy & sink_rdy & !abort;
                expect_eq("col_valid", col_valid, exp_cv);
                if (exp_cv) begin
                    expect_eq("col_idx", col_idx, acc_n);
                    expect_eq("pipe_col", p_col, acc_n);
                    expect_eq("pipe_req", pipe_req,
                              !pipe_last && acc_n != NCOLS - 1);
                    if (pipe_last || acc_n == NCOLS - 1) begin
                        phase = 2;
                        last_cyc = cyc;
                    end
                    acc_n++;
                end else begin
                    expect_eq("req_stall", pipe_req, 0);
                end
                if (!pipe_rdy && busy) low_n++;
            end else if (phase == 0) begin
                if (col_valid) cv_pre++;
                if (pipe_req) phase = 1;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (cyc >= 1 && !busy) begin
                ended = 1'b1;
                end_cyc = cyc;
            end
            s_req = pipe_req;
            s_si = stage_init;
            @(posedge clock);
            #1;
            start = 1'b0;
            abort = 1'b0;
            pipe_step(s_req, s_si);
        end
        expect_eq("frame_ended", ended, 1);
        if (kind != K_RST) begin
            exp_cols = (kind == K_TMO) ? 0 :
                       (kind == K_ABORT) ? ev_at :
                       (last_at < NCOLS - 1) ? last_at + 1 : NCOLS;
            exp_err = (kind == K_TMO) ||
                      (kind == K_NORM && last_at != NCOLS - 1);
            if (kind == K_NORM) fc_exp++;
            expect_eq("cols", acc_n, exp_cols);
            expect_eq("done_cnt", done_n, kind == K_NORM);
            expect_eq("init_cycles", si_n, 2);
            expect_eq("prime_no_valid", cv_pre, 0);
            expect_eq("err", err, exp_err);
            expect_eq("frame_cnt", frame_cnt, fc_exp % (1 << FW));
            if (kind == K_NORM)
                expect_eq("done_lat", done_cyc - last_cyc, 1);
            if (kind == K_TMO)
                expect_eq("tmo_cycles", low_n, TIMEOUT);
            if (kind == K_ABORT)
                expect_eq("abort_lat", end_cyc - abort_cyc, 1);
            idle_cycles(2, "after");
        end
    endtask

    initial begin
        init_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        expect_eq("reset_stage_init", stage_init, 1);
        expect_eq("reset_busy", busy, 0);
        expect_eq("reset_frame_cnt", frame_cnt, 0);
        expect_eq("reset_col_idx", col_idx, 0);
        expect_eq("reset_err", err, 0);
        #2 init_n = 1'b1;
        @(posedge clock);
        #1;
        run_frame(K_NORM, NCOLS - 1, 100, 0, -1, -1, 3000);
        run_frame(K_NORM, NCOLS - 1, 50, 2, -1, -1, 6000);
        run_frame(K_NORM, 9, 100, 1, -1, -1, 500);
        run_frame(K_NORM, 1000, 70, 1, -1, -1, 4000);
        run_frame(K_TMO, NCOLS - 1, 60, 0, -1, -1, 3000);
        run_frame(K_NORM, NCOLS - 1, 80, 1, -1, -1, 4000);
        run_frame(K_ABORT, NCOLS - 1, 100, 0, 20, 100, 3000);
        run_frame(K_NORM, NCOLS - 1, 90, 1, -1, -1, 4000);
        run_frame(K_RST, NCOLS - 1, 100, 0, -1, 50, 3000);
        run_frame(K_NORM, NCOLS - 1, 75, 1, -1, -1, 4000);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
